// File: rtl/uart_receiver.sv
// Purpose: 8N1 UART receiver, mid-bit sampling, byte handed to consumer over four-phase REQ/ACK.
// Latency: RCV_REQ rises BIT_CYCLES/2 + 9*BIT_CYCLES + 1 cycles after rx_s first goes low (+2 sync).
// Backpressure: reception never stalls; a frame finishing while REQ or ACK is high is dropped with OVR_ERR.
module uart_receiver #(
    // Clocks per serial bit; must be even and at least 4.
    parameter int BIT_CYCLES = 8
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       RCV,
    output logic [7:0] RCV_DATA,
    output logic       RCV_REQ,
    input  logic       RCV_ACK,
    output logic       FRM_ERR,
    output logic       OVR_ERR,
    output logic       RCV_BUSY
);

    localparam int CW = $clog2(BIT_CYCLES);
    // The cycle counter counts down to zero, so it only needs to hold B-1 and H-1.
    localparam logic [CW-1:0] HALF_M1 = CW'(BIT_CYCLES / 2 - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(BIT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync1_d;
    logic          rx_s_q, rx_s_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          req_q, req_d;
    logic          frm_q, frm_d;
    logic          ovr_q, ovr_d;
    logic          tick;

    // Two-flop synchronizer input path; idle-high line so both stages preset to 1.
    always_comb begin
        sync1_d = RCV;
        rx_s_d  = sync1_q;
    end

    // Register bank: synchronizer, FSM state, counters and output flops.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            req_q   <= 1'b0;
            frm_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            rx_s_q  <= rx_s_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            req_q   <= req_d;
            frm_q   <= frm_d;
            ovr_q   <= ovr_d;
        end
    end

    // Sample point reached when the down-counter hits zero.
    assign tick = (cnt_q == '0);

    // Next-state, bit sampling, delivery gating and handshake release.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        req_d   = req_q;
        frm_d   = 1'b0;
        ovr_d   = 1'b0;

        // Four-phase release: REQ drops the cycle after ACK is seen high.
        if (req_q && RCV_ACK) begin
            req_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (!rx_s_q) begin
                    state_d = ST_START;
                    cnt_d   = HALF_M1;
                    bit_d   = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (rx_s_q) begin
                        // Start bit gone by mid-bit: treat as a glitch.
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                        cnt_d   = BIT_M1;
                        bit_d   = 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d = {rx_s_q, shift_q[7:1]};
                    cnt_d   = BIT_M1;
                    bit_d   = bit_q + 4'd1;
                    if (bit_q == 4'd8) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    bit_d = '0;
                    if (rx_s_q) begin
                        // Back to IDLE half a bit early so an immediate next start edge is seen.
                        state_d = ST_IDLE;
                        // ACK still high (even with REQ low) means the consumer is not ready.
                        if (!req_q && !RCV_ACK) begin
                            data_d = shift_q;
                            req_d  = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        frm_d   = 1'b1;
                        state_d = ST_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_BREAK: begin
                // Line held low after a bad stop bit: one error only, wait for idle.
                if (rx_s_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign RCV_DATA = data_q;
    assign RCV_REQ  = req_q;
    assign FRM_ERR  = frm_q;
    assign OVR_ERR  = ovr_q;
    assign RCV_BUSY = (state_q != ST_IDLE);

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
Serial receiver for the UART link, directly downstream of the transmit block. It takes the serial line (idle high, one start bit low, 8 data bits LSB first, stop bit high) and recovers each byte by sampling at mid-bit. Each good byte goes to the consuming logic through a four-phase REQ/ACK handshake that mirrors the transmit side. The block flags framing errors and overruns.

Parameters:
BIT_CYCLES, 8, clk cycles per serial bit; must be even and >= 4. The default matches the transmitter's bit period: 2*(count_to+1) with count_to=3.

Ports:
clk  input  1  system clock, all logic on rising edge
clr  input  1  reset, asynchronous, active-low (asserted when 0)
RCV  input  1  serial line in, asynchronous to clk, idle high
RCV_DATA  output  8  received byte, valid while RCV_REQ=1
RCV_REQ  output  1  byte available request to consumer
RCV_ACK  input  1  consumer acknowledge
FRM_ERR  output  1  one-cycle pulse: stop bit sampled low
OVR_ERR  output  1  one-cycle pulse: frame completed while handshake busy, byte dropped
RCV_BUSY  output  1  high in any state other than IDLE

Behaviour:
- Reset (clr=0, async): state=IDLE. Both synchronizer flops preset to 1. RCV_DATA=0x00; RCV_REQ, FRM_ERR, OVR_ERR, RCV_BUSY=0. Bit and cycle counters cleared. Reset mid-frame abandons the frame with no error pulse.
- Input sync: RCV passes through a 2-flop synchronizer to give rx_s. All decisions use rx_s. Pin-to-rx_s latency is 2 cycles.
- Counters: the cycle counter is $clog2(BIT_CYCLES) bits. The bit index is 4 bits (0..9).
- Let H = BIT_CYCLES/2 and B = BIT_CYCLES. Let t0 be the first cycle in IDLE with rx_s=0.
- IDLE: wait for rx_s=0, then go to START and load the counter.
- START: sample rx_s at t0+H.
  - Sample =1: false start (glitch). Return to IDLE with no error.
  - Sample =0: go to DATA.
- DATA: sample at t0+H+k*B for k=1..8. Shift each sample into shift_reg at the MSB (right shift), so bit 0 arrives first. After k=8, go to STOP.
- STOP: sample at t0+H+9*B.
  - Sample =1: frame good. Go to IDLE.
  - Sample =0: FRM_ERR=1 for exactly one cycle, no byte delivered. Go to BREAK.
- BREAK: wait for rx_s=1, then go to IDLE. A held-low line gives exactly one FRM_ERR.
- Good frame delivery:
  - Condition: RCV_REQ=0 and RCV_ACK=0.
  - Action: on the cycle after the stop sample, RCV_DATA<=shift_reg and RCV_REQ<=1. Frame latency from t0 is H+9*B+1 cycles.
  - If the condition fails: OVR_ERR=1 for one cycle on that cycle, the byte is dropped, and RCV_DATA is unchanged.
- Handshake (four-phase):
  - RCV_REQ stays high, and RCV_DATA holds stable, until RCV_ACK=1 is sampled.
  - RCV_REQ drops on the cycle after RCV_ACK is seen high.
  - RCV_ACK high while RCV_REQ=0 is ignored but blocks delivery (counts as busy).
  - RCV_DATA holds its last value after REQ drops.
- Reception continues during a pending handshake, so a new frame shifts while REQ=1. Only delivery is gated.
- Back-to-back frames: a start bit may begin immediately after the stop sample. IDLE is re-entered H cycles before the stop bit ends, so a falling edge right at the stop/start boundary is caught.
- Simultaneous delivery and RCV_ACK rise: the ACK is seen by the old REQ, so delivery is blocked and OVR_ERR fires. The consumer must release ACK first.
- FRM_ERR and OVR_ERR never assert in the same cycle. A framing error is never an overrun.
- No parity is checked. The 8th data bit is ordinary data.

Test Plan:
- Reset, then drive the frame for 0xA5 at 8 clk/bit (start edge at pin cycle 10) -> RCV_REQ rises at pin cycle 10+2+4+72+1=89, RCV_DATA=0xA5, FRM_ERR=OVR_ERR=0. Raise RCV_ACK -> REQ low the next cycle.
- Pulse RCV low for 3 cycles, then hold high -> no state beyond START, RCV_REQ stays 0, no error pulses, RCV_BUSY returns to 0 within 6 cycles.
- Frame 0x3C with stop bit driven 0, then line held low 40 cycles, then high -> single FRM_ERR pulse, RCV_REQ=0. Next frame 0x81 is received correctly.
- Frame 0x11 not acknowledged, then frame 0x22 -> OVR_ERR pulse at the second frame's delivery cycle, RCV_DATA stays 0x11, RCV_REQ stays 1. After ACK and release, frame 0x33 is delivered.
- Assert clr=0 for 2 cycles midway through the data bits of 0xFF -> all outputs 0 immediately (async). A fresh frame 0x5A after release is delivered correctly.
- Loopback: connect the transmitter XMT output to RCV with shared clk, and send 0x00, 0xFF, 0x55, 0xAA -> each byte matches on RCV_DATA with no FRM_ERR or OVR_ERR.
